decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  ID stage of the 5-stage pipeline, directly downstream of Fetch. It consumes the IF/ID
//  instruction and next-PC, and reads the 32x32 register file, which it owns and which
//  Writeback writes. It resolves branches and jumps for Fetch and registers decoded
//  operands and control into the ID/EX pipeline register. One architectural delay slot.
// PARAMETERS
//  EXC_VECTOR  32'h0000_0040  redirect target for illegal opcodes (selpctype 2'b11)
// PORTS
//  clock             in   1   rising-edge clock
//  reset             in   1   asynchronous, active-low
//  if_id_instruc     in   32  instruction from Fetch; 32'h0 = bubble/nop
//  if_id_nextpc      in   32  fall-through PC of the instruction in ID
//  ex_if_stall       in   1   Execute stall, shared with Fetch
//  wb_id_we          in   1   register-file write enable
//  wb_id_regdest     in   5   register-file write index
//  wb_id_writedata   in   32  register-file write data
//  id_if_selpcsource out  1   redirect Fetch this cycle
//  id_if_selpctype   out  2   00 branch, 01 jr, 10 j/jal, 11 exception
//  id_if_pcimd2ext   out  32  if_id_nextpc + (sext(imm16) << 2)
//  id_if_rega        out  32  rs value (bypassed), used as jr target
//  id_if_pcindex     out  32  {if_id_nextpc[31:28], instr[25:0], 2'b00}
//  id_ex_rega        out  32  registered operand A
//  id_ex_regb        out  32  registered operand B (rt value)
//  id_ex_imedext     out  32  registered extended immediate
//  id_ex_regdest     out  5   registered destination index
//  id_ex_aluop       out  3   000 add,001 sub,010 and,011 or,100 slt,101 sll,110 srl,111 lui
//  id_ex_selimm      out  1   1: ALU operand B = imedext
//  id_ex_writereg    out  1   registered register-write enable
//  id_ex_readmem     out  1   lw
//  id_ex_writemem    out  1   sw
// BEHAVIOUR
//  Reset: all 32 registers and all id_ex_* outputs go to 0, asynchronously.
//  Register file: $0 reads 0 and ignores writes; writes occur on posedge when wb_id_we=1.
//  Read bypass: same-cycle write to a nonzero index equal to rs/rt returns wb_id_writedata.
//  Decode: R-type op 0 with funct add 20, sub 22, and 24, or 25, slt 2A, sll 00, srl 02, jr 08.
//  I-type and J-type: addi 08, ori 0D (zero-extended), lui 0F, lw 23, sw 2B, beq 04, bne 05,
//  j 02, jal 03. Shift amount goes in imedext[4:0].
//  R-type destination is rd; I-type destination is rt; jal destination is 31 with
//  id_ex_rega=if_id_nextpc and aluop=add, imm=0.
//  Branch/jump outputs are combinational from the IF/ID inputs and register reads. Fetch
//  samples them on the same edge, so branch resolution adds 0 extra cycles.
//  selpcsource=1 when: beq taken (rs==rt), bne taken, j, jal, jr, or illegal op/funct.
//  An illegal instruction selects type 11 and is dispatched to EX as a bubble.
//  ex_if_stall=1 forces selpcsource=0. Fetch ignores redirects while stalled.
//  ID/EX register: loads every posedge. Bubbles are a zero instruction, beq/bne/j/jr and
//  illegal ops; a bubble sets writereg=readmem=writemem=0.
//  Writes to $0 are dispatched with writereg=0.
//  Arithmetic: all 32-bit and wraps modulo 2^32. Branch offsets are sign-extended before
//  the shift. pcindex takes its top 4 bits from if_id_nextpc.
//  Reset mid-operation: the register file and ID/EX clear immediately, and the redirect
//  outputs follow the (reset-zeroed) IF/ID inputs.
// TESTING
//  Reset, then instruc=0 -> all id_ex_* are 0, selpcsource=0.
//  Write $5=7 via WB, then addi $6,$5,3 -> id_ex_rega=7, imedext=3, regdest=6, writereg=1, selimm=1.
//  WB writes $5=9 in the same cycle as add $7,$5,$5 is decoded -> id_ex_rega=regb=9 (bypass).
//  beq $1,$2,-1 with $1=$2=4, nextpc=0x100 -> selpcsource=1, type=00, pcimd2ext=0xFC; EX gets a bubble.
//  jr $31 with $31=0x200 and ex_if_stall=1 -> selpcsource=0; with ex_if_stall=0 -> redirect to 0x200, type=01.
//  Opcode 0x3F -> selpcsource=1, type=11 (EXC_VECTOR 0x40); writeback of $0 with data 5 leaves $0 reading 0.

Source files
------------

// File: rtl/decode_stage.sv
// ID stage: owns the 32x32 register file, decodes the IF/ID instruction, resolves
// branches/jumps combinationally for Fetch and registers operands/control into ID/EX.
module decode_stage #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] if_id_instruc,
  input  logic [31:0] if_id_nextpc,
  input  logic        ex_if_stall,
  input  logic        wb_id_we,
  input  logic [4:0]  wb_id_regdest,
  input  logic [31:0] wb_id_writedata,
  output logic        id_if_selpcsource,
  output logic [1:0]  id_if_selpctype,
  output logic [31:0] id_if_pcimd2ext,
  output logic [31:0] id_if_rega,
  output logic [31:0] id_if_pcindex,
  output logic [31:0] id_ex_rega,
  output logic [31:0] id_ex_regb,
  output logic [31:0] id_ex_imedext,
  output logic [4:0]  id_ex_regdest,
  output logic [2:0]  id_ex_aluop,
  output logic        id_ex_selimm,
  output logic        id_ex_writereg,
  output logic        id_ex_readmem,
  output logic        id_ex_writemem
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;
  localparam logic [2:0] AluSll = 3'b101;
  localparam logic [2:0] AluSrl = 3'b110;
  localparam logic [2:0] AluLui = 3'b111;

  logic [31:0] regs [32];

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;

  assign opcode = if_id_instruc[31:26];
  assign rs     = if_id_instruc[25:21];
  assign rt     = if_id_instruc[20:16];
  assign rd     = if_id_instruc[15:11];
  assign shamt  = if_id_instruc[10:6];
  assign funct  = if_id_instruc[5:0];
  assign imm    = if_id_instruc[15:0];

  logic [31:0] rs_val;
  logic [31:0] rt_val;

  // Register reads with same-cycle writeback bypass; $0 is hardwired to zero.
  always_comb begin
    rs_val = regs[rs];
    rt_val = regs[rt];
    if (rs == 5'd0) begin
      rs_val = '0;
    end else if (wb_id_we && wb_id_regdest == rs) begin
      rs_val = wb_id_writedata;
    end
    if (rt == 5'd0) begin
      rt_val = '0;
    end else if (wb_id_we && wb_id_regdest == rt) begin
      rt_val = wb_id_writedata;
    end
  end

  // Register file: asynchronously cleared, written by Writeback, $0 never written.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_id_we && wb_id_regdest != 5'd0) begin
      regs[wb_id_regdest] <= wb_id_writedata;
    end
  end

  logic        illegal;
  logic        bubble;
  logic        take_branch;
  logic        is_jump;
  logic        is_jr;
  logic [2:0]  aluop_d;
  logic        selimm_d;
  logic        writereg_d;
  logic        readmem_d;
  logic        writemem_d;
  logic [4:0]  dest_d;
  logic [31:0] imedext_d;
  logic [31:0] rega_d;
  logic [31:0] regb_d;

  // Instruction decode into ID/EX control, operands and redirect class.
  always_comb begin
    illegal     = 1'b0;
    bubble      = 1'b0;
    take_branch = 1'b0;
    is_jump     = 1'b0;
    is_jr       = 1'b0;
    aluop_d     = AluAdd;
    selimm_d    = 1'b1;
    writereg_d  = 1'b0;
    readmem_d   = 1'b0;
    writemem_d  = 1'b0;
    dest_d      = rt;
    imedext_d   = {{16{imm[15]}}, imm};
    rega_d      = rs_val;
    regb_d      = rt_val;
    case (opcode)
      OpRtype: begin
        dest_d     = rd;
        imedext_d  = {27'd0, shamt};
        selimm_d   = 1'b0;
        writereg_d = 1'b1;
        case (funct)
          FnAdd:   aluop_d = AluAdd;
          FnSub:   aluop_d = AluSub;
          FnAnd:   aluop_d = AluAnd;
          FnOr:    aluop_d = AluOr;
          FnSlt:   aluop_d = AluSlt;
          FnSll:   aluop_d = AluSll;
          FnSrl:   aluop_d = AluSrl;
          FnJr: begin
            is_jr  = 1'b1;
            bubble = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OpAddi: writereg_d = 1'b1;
      OpOri: begin
        aluop_d    = AluOr;
        imedext_d  = {16'd0, imm};
        writereg_d = 1'b1;
      end
      OpLui: begin
        aluop_d    = AluLui;
        imedext_d  = {16'd0, imm};
        writereg_d = 1'b1;
      end
      OpLw: begin
        readmem_d  = 1'b1;
        writereg_d = 1'b1;
      end
      OpSw: writemem_d = 1'b1;
      OpBeq: begin
        take_branch = (rs_val == rt_val);
        bubble      = 1'b1;
      end
      OpBne: begin
        take_branch = (rs_val != rt_val);
        bubble      = 1'b1;
      end
      OpJ: begin
        is_jump = 1'b1;
        bubble  = 1'b1;
      end
      OpJal: begin
        // Link value flows through the ALU as nextpc + 0.
        is_jump    = 1'b1;
        dest_d     = 5'd31;
        rega_d     = if_id_nextpc;
        regb_d     = '0;
        imedext_d  = '0;
        writereg_d = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (if_id_instruc == 32'd0) begin
      bubble = 1'b1;
    end
  end

  // Redirect information for Fetch, combinational so branches cost no extra cycle.
  always_comb begin
    id_if_selpcsource = (take_branch | is_jump | is_jr | illegal) & ~ex_if_stall;
    if (illegal) begin
      id_if_selpctype = 2'b11;
    end else if (is_jr) begin
      id_if_selpctype = 2'b01;
    end else if (is_jump) begin
      id_if_selpctype = 2'b10;
    end else begin
      id_if_selpctype = 2'b00;
    end
    id_if_pcimd2ext = if_id_nextpc + {{14{imm[15]}}, imm, 2'b00};
    id_if_rega      = rs_val;
    id_if_pcindex   = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};
  end

  // Fetch jumps to EXC_VECTOR on type 11, so it has to be a word address.
  always_comb begin
    assert (id_if_selpctype != 2'b11 || EXC_VECTOR[1:0] == 2'b00);
  end

  // ID/EX pipeline register; bubbles and illegal ops dispatch as all-zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_ex_rega     <= '0;
      id_ex_regb     <= '0;
      id_ex_imedext  <= '0;
      id_ex_regdest  <= '0;
      id_ex_aluop    <= '0;
      id_ex_selimm   <= 1'b0;
      id_ex_writereg <= 1'b0;
      id_ex_readmem  <= 1'b0;
      id_ex_writemem <= 1'b0;
    end else if (bubble || illegal) begin
      id_ex_rega     <= '0;
      id_ex_regb     <= '0;
      id_ex_imedext  <= '0;
      id_ex_regdest  <= '0;
      id_ex_aluop    <= '0;
      id_ex_selimm   <= 1'b0;
      id_ex_writereg <= 1'b0;
      id_ex_readmem  <= 1'b0;
      id_ex_writemem <= 1'b0;
    end else begin
      id_ex_rega     <= rega_d;
      id_ex_regb     <= regb_d;
      id_ex_imedext  <= imedext_d;
      id_ex_regdest  <= dest_d;
      id_ex_aluop    <= aluop_d;
      id_ex_selimm   <= selimm_d;
      id_ex_writereg <= writereg_d && (dest_d != 5'd0);
      id_ex_readmem  <= readmem_d;
      id_ex_writemem <= writemem_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected ID/EX contents,
// a monitor pops and compares after each rising edge.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_id_instruc;
  logic [31:0] if_id_nextpc;
  logic        ex_if_stall;
  logic        wb_id_we;
  logic [4:0]  wb_id_regdest;
  logic [31:0] wb_id_writedata;
  logic        id_if_selpcsource;
  logic [1:0]  id_if_selpctype;
  logic [31:0] id_if_pcimd2ext;
  logic [31:0] id_if_rega;
  logic [31:0] id_if_pcindex;
  logic [31:0] id_ex_rega;
  logic [31:0] id_ex_regb;
  logic [31:0] id_ex_imedext;
  logic [4:0]  id_ex_regdest;
  logic [2:0]  id_ex_aluop;
  logic        id_ex_selimm;
  logic        id_ex_writereg;
  logic        id_ex_readmem;
  logic        id_ex_writemem;

  decode_stage #(.EXC_VECTOR(32'h0000_0040)) dut (
    .clock            (clock),
    .reset            (reset),
    .if_id_instruc    (if_id_instruc),
    .if_id_nextpc     (if_id_nextpc),
    .ex_if_stall      (ex_if_stall),
    .wb_id_we         (wb_id_we),
    .wb_id_regdest    (wb_id_regdest),
    .wb_id_writedata  (wb_id_writedata),
    .id_if_selpcsource(id_if_selpcsource),
    .id_if_selpctype  (id_if_selpctype),
    .id_if_pcimd2ext  (id_if_pcimd2ext),
    .id_if_rega       (id_if_rega),
    .id_if_pcindex    (id_if_pcindex),
    .id_ex_rega       (id_ex_rega),
    .id_ex_regb       (id_ex_regb),
    .id_ex_imedext    (id_ex_imedext),
    .id_ex_regdest    (id_ex_regdest),
    .id_ex_aluop      (id_ex_aluop),
    .id_ex_selimm     (id_ex_selimm),
    .id_ex_writereg   (id_ex_writereg),
    .id_ex_readmem    (id_ex_readmem),
    .id_ex_writemem   (id_ex_writemem)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] rega;
    logic [31:0] regb;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [2:0]  aluop;
    logic        selimm;
    logic        writereg;
    logic        readmem;
    logic        writemem;
  } idex_t;

  idex_t exp_q[$];
  int    tag_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic idex_t mk(input logic [31:0] ra, input logic [31:0] rb,
                               input logic [31:0] im, input logic [4:0] d,
                               input logic [2:0] op, input logic si, input logic wr,
                               input logic rm, input logic wm);
    idex_t e;
    e.rega = ra; e.regb = rb; e.imm = im; e.dest = d; e.aluop = op;
    e.selimm = si; e.writereg = wr; e.readmem = rm; e.writemem = wm;
    return e;
  endfunction

  function automatic idex_t actual();
    return mk(id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_regdest, id_ex_aluop,
              id_ex_selimm, id_ex_writereg, id_ex_readmem, id_ex_writemem);
  endfunction

  function automatic logic [31:0] rt_i(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // Drive one instruction (plus optional writeback) and enqueue its ID/EX expectation.
  task automatic issue(input logic [31:0] ins, input logic [31:0] npc, input logic stall,
                       input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                       input idex_t e, input int tag);
    @(negedge clock);
    reset           = 1'b1;
    if_id_instruc   = ins;
    if_id_nextpc    = npc;
    ex_if_stall     = stall;
    wb_id_we        = we;
    wb_id_regdest   = wd;
    wb_id_writedata = wdat;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
  endtask

  // Monitor: ID/EX is presented every cycle, compare against the oldest expectation.
  initial begin
    idex_t e;
    int    t;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (actual() !== e) begin
          errors++;
          $display("FAIL idex[%0d] got=%h expected=%h", t, actual(), e);
        end
      end
    end
  end

  initial begin
    idex_t z;
    z = '0;
    reset = 1'b0;
    if_id_instruc = '0; if_id_nextpc = '0; ex_if_stall = 1'b0;
    wb_id_we = 1'b0; wb_id_regdest = '0; wb_id_writedata = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_idex", {31'd0, actual() == z}, 32'd1);
    chk("reset_sel", {31'd0, id_if_selpcsource}, 32'd0);

    issue(32'd0, 32'h0, 0, 0, 0, 0, z, 1);
    chk("nop_sel", {31'd0, id_if_selpcsource}, 32'd0);
    issue(32'd0, 32'h0, 0, 1, 5'd5, 32'd7, z, 2);
    // addi $6,$5,3
    issue(it_i(6'h08, 5, 6, 16'd3), 32'h0, 0, 0, 0, 0, mk(7, 0, 3, 6, 3'b000, 1, 1, 0, 0), 3);
    // add $7,$5,$5 while $5<=9 is written back
    issue(rt_i(5, 5, 7, 0, 6'h20), 32'h0, 0, 1, 5'd5, 32'd9,
          mk(9, 9, 0, 7, 3'b000, 0, 1, 0, 0), 4);
    issue(32'd0, 32'h0, 0, 1, 5'd1, 32'd4, z, 5);
    issue(32'd0, 32'h0, 0, 1, 5'd2, 32'd4, z, 6);
    // beq $1,$2,-1 taken
    issue(it_i(6'h04, 1, 2, 16'hFFFF), 32'h100, 0, 0, 0, 0, z, 7);
    chk("beq_sel", {31'd0, id_if_selpcsource}, 32'd1);
    chk("beq_type", {30'd0, id_if_selpctype}, 32'd0);
    chk("beq_target", id_if_pcimd2ext, 32'h0000_00FC);
    // bne $1,$2,-1 not taken
    issue(it_i(6'h05, 1, 2, 16'hFFFF), 32'h100, 0, 0, 0, 0, z, 8);
    chk("bne_sel", {31'd0, id_if_selpcsource}, 32'd0);
    issue(32'd0, 32'h0, 0, 1, 5'd31, 32'h200, z, 9);
    // jr $31 stalled then free
    issue(rt_i(31, 0, 0, 0, 6'h08), 32'h0, 1, 0, 0, 0, z, 10);
    chk("jr_stall_sel", {31'd0, id_if_selpcsource}, 32'd0);
    issue(rt_i(31, 0, 0, 0, 6'h08), 32'h0, 0, 0, 0, 0, z, 11);
    chk("jr_sel", {31'd0, id_if_selpcsource}, 32'd1);
    chk("jr_type", {30'd0, id_if_selpctype}, 32'd1);
    chk("jr_target", id_if_rega, 32'h200);
    // illegal opcode 0x3F
    issue(32'hFC00_0000, 32'h0, 0, 0, 0, 0, z, 12);
    chk("ill_sel", {31'd0, id_if_selpcsource}, 32'd1);
    chk("ill_type", {30'd0, id_if_selpctype}, 32'd3);
    // add $8,$0,$5 while WB targets $0 with 5
    issue(rt_i(0, 5, 8, 0, 6'h20), 32'h0, 0, 1, 5'd0, 32'd5,
          mk(0, 9, 0, 8, 3'b000, 0, 1, 0, 0), 13);
    issue(rt_i(0, 0, 9, 0, 6'h20), 32'h0, 0, 0, 0, 0, mk(0, 0, 0, 9, 3'b000, 0, 1, 0, 0), 14);
    // j 0x123456 from 0xA0000010
    issue({6'h02, 26'h123456}, 32'hA000_0010, 0, 0, 0, 0, z, 15);
    chk("j_sel", {31'd0, id_if_selpcsource}, 32'd1);
    chk("j_type", {30'd0, id_if_selpctype}, 32'd2);
    chk("j_target", id_if_pcindex, 32'hA048_D158);
    // jal 0x10 from 0x300
    issue({6'h03, 26'h10}, 32'h300, 0, 0, 0, 0, mk(32'h300, 0, 0, 31, 3'b000, 1, 1, 0, 0), 16);
    chk("jal_sel", {31'd0, id_if_selpcsource}, 32'd1);
    chk("jal_target", id_if_pcindex, 32'h0000_0040);
    issue(rt_i(5, 1, 10, 0, 6'h22), 32'h0, 0, 0, 0, 0, mk(9, 4, 0, 10, 3'b001, 0, 1, 0, 0), 17);
    issue(it_i(6'h0D, 5, 11, 16'h8001), 32'h0, 0, 0, 0, 0,
          mk(9, 0, 32'h8001, 11, 3'b011, 1, 1, 0, 0), 18);
    issue(it_i(6'h23, 5, 12, 16'hFFFC), 32'h0, 0, 0, 0, 0,
          mk(9, 0, 32'hFFFF_FFFC, 12, 3'b000, 1, 1, 1, 0), 19);
    issue(it_i(6'h2B, 5, 1, 16'd8), 32'h0, 0, 0, 0, 0, mk(9, 4, 8, 1, 3'b000, 1, 0, 0, 1), 20);
    issue(rt_i(0, 1, 13, 3, 6'h00), 32'h0, 0, 0, 0, 0, mk(0, 4, 3, 13, 3'b101, 0, 1, 0, 0), 21);
    issue(it_i(6'h08, 5, 0, 16'd1), 32'h0, 0, 0, 0, 0, mk(9, 0, 1, 0, 3'b000, 1, 0, 0, 0), 22);
    issue(it_i(6'h0F, 0, 14, 16'h1234), 32'h0, 0, 0, 0, 0,
          mk(0, 0, 32'h1234, 14, 3'b111, 1, 1, 0, 0), 23);
    // R-type with undefined funct
    issue(rt_i(5, 5, 3, 0, 6'h3F), 32'h0, 0, 0, 0, 0, z, 24);
    chk("illfn_type", {30'd0, id_if_selpctype}, 32'd3);
    issue(rt_i(5, 5, 7, 0, 6'h20), 32'h0, 0, 0, 0, 0, mk(9, 9, 0, 7, 3'b000, 0, 1, 0, 0), 25);

    // Reset mid-operation clears ID/EX at once and wipes the register file.
    @(negedge clock);
    reset = 1'b0;
    if_id_instruc = '0;
    exp_q.push_back(z);
    tag_q.push_back(26);
    #1;
    chk("midreset_idex", {31'd0, actual() == z}, 32'd1);
    issue(rt_i(5, 1, 15, 0, 6'h20), 32'h0, 0, 0, 0, 0, mk(0, 0, 0, 15, 3'b000, 0, 1, 0, 0), 27);

    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
